// File: rtl/multi_debounce.sv
// multi_debounce: N-channel push-button / switch debouncer.
// Each channel synchronises its raw pin and accepts a new level only after
// that level has been stable for DEBOUNCE_CYCLES. It reports the debounced
// level plus one-cycle press (rise), release (fall) and hold/auto-repeat
// (hold) strobes. All outputs are registered.
//
// Ports:
//   clk    in   system clock
//   rst    in   synchronous active-high reset
//   D      in   [CHANNELS] raw asynchronous button inputs
//   level  out  [CHANNELS] debounced level (1 = pressed)
//   rise   out  [CHANNELS] one-cycle strobe on accepted press
//   fall   out  [CHANNELS] one-cycle strobe on accepted release
//   hold   out  [CHANNELS] one-cycle hold / auto-repeat strobe
module multi_debounce #(
  parameter int unsigned CHANNELS        = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 3600000,
  parameter int unsigned HOLD_CYCLES     = 24000000,
  parameter int unsigned REPEAT_CYCLES   = 4800000,
  parameter int unsigned ACTIVE_LOW      = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] D,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic [CHANNELS-1:0] hold
);

  localparam int unsigned DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned HR_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int unsigned HC_W   = (HR_MAX > 1) ? $clog2(HR_MAX) : 1;

  // Terminal counts; the unused ones wrap harmlessly when a parameter is 0.
  localparam logic [DB_W-1:0] DB_TERM   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HC_W-1:0] HOLD_TERM = HC_W'(HOLD_CYCLES - 1);
  localparam logic [HC_W-1:0] REP_TERM  = HC_W'(REPEAT_CYCLES - 1);
  localparam logic            INV       = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

  typedef enum logic [1:0] {
    ST_REL = 2'd0,
    ST_PRS = 2'd1,
    ST_RPT = 2'd2
  } hold_state_e;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic            sync1_q, sync2_q;
    logic            ds;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic            level_q, level_d;
    logic            rise_q, rise_d;
    logic            fall_q, fall_d;

    assign ds = sync2_q ^ INV;

    // Debounce: count while ds disagrees with the accepted level.
    always_comb begin
      db_cnt_d = db_cnt_q;
      level_d  = level_q;
      rise_d   = 1'b0;
      fall_d   = 1'b0;
      if (ds == level_q) begin
        db_cnt_d = '0;
      end else if (db_cnt_q == DB_TERM) begin
        db_cnt_d = '0;
        level_d  = ds;
        rise_d   = ds;
        fall_d   = ~ds;
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end

    // Synchroniser and debounce registers.
    always_ff @(posedge clk) begin
      if (rst) begin
        sync1_q  <= 1'b0;
        sync2_q  <= 1'b0;
        db_cnt_q <= '0;
        level_q  <= 1'b0;
        rise_q   <= 1'b0;
        fall_q   <= 1'b0;
      end else begin
        sync1_q  <= D[i];
        sync2_q  <= sync1_q;
        db_cnt_q <= db_cnt_d;
        level_q  <= level_d;
        rise_q   <= rise_d;
        fall_q   <= fall_d;
      end
    end

    assign level[i] = level_q;
    assign rise[i]  = rise_q;
    assign fall[i]  = fall_q;

    if (HOLD_CYCLES == 0) begin : g_no_hold
      assign hold[i] = 1'b0;
    end else begin : g_hold
      hold_state_e     state_q, state_d;
      logic [HC_W-1:0] hcnt_q, hcnt_d;
      logic            hold_q, hold_d;

      // Hold FSM state register.
      always_ff @(posedge clk) begin
        if (rst) begin
          state_q <= ST_REL;
          hcnt_q  <= '0;
          hold_q  <= 1'b0;
        end else begin
          state_q <= state_d;
          hcnt_q  <= hcnt_d;
          hold_q  <= hold_d;
        end
      end

      // Hold FSM next state; driven by the same-edge accept events so the
      // first hold lands exactly HOLD_CYCLES after the rise strobe.
      always_comb begin
        state_d = state_q;
        hcnt_d  = hcnt_q;
        hold_d  = 1'b0;
        case (state_q)
          ST_REL: begin
            hcnt_d = '0;
            if (rise_d) state_d = ST_PRS;
          end
          ST_PRS: begin
            if (hcnt_q == HOLD_TERM) begin
              hold_d  = 1'b1;
              hcnt_d  = '0;
              state_d = ST_RPT;
            end else begin
              hcnt_d = hcnt_q + HC_W'(1);
            end
          end
          ST_RPT: begin
            // With no repeat period the counter stays frozen.
            if (REPEAT_CYCLES != 0) begin
              if (hcnt_q == REP_TERM) begin
                hold_d = 1'b1;
                hcnt_d = '0;
              end else begin
                hcnt_d = hcnt_q + HC_W'(1);
              end
            end
          end
          default: begin
            state_d = ST_REL;
            hcnt_d  = '0;
          end
        endcase
        // Release overrides everything, including a coincident hold.
        if (fall_d) begin
          state_d = ST_REL;
          hcnt_d  = '0;
          hold_d  = 1'b0;
        end
      end

      assign hold[i] = hold_q;
    end
  end

endmodule

// File: tb/tb_multi_debounce.sv
// Testbench for multi_debounce: directed stimulus pushes expected strobe
// events into per-instance queues; a monitor pops and compares whenever a
// DUT presents any strobe, and checks outputs are clear after reset edges.
module tb_multi_debounce;

  typedef struct {
    int         cyc;
    logic [3:0] r;
    logic [3:0] f;
    logic [3:0] h;
    logic [3:0] l;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_a, rst_b;
  logic [3:0] d_a, d_b;
  logic [3:0] level_a, rise_a, fall_a, hold_a;
  logic [3:0] level_b, rise_b, fall_b, hold_b;
  logic       rst_a_s, rst_b_s;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   drain_cnt = 0;
  bit   stim_done = 1'b0;
  exp_t qa[$];
  exp_t qb[$];

  always #5 clk = ~clk;

  // Main instance: debounce 4, hold 10, repeat 5, active-high.
  multi_debounce #(
    .CHANNELS(4), .DEBOUNCE_CYCLES(4), .HOLD_CYCLES(10),
    .REPEAT_CYCLES(5), .ACTIVE_LOW(0)
  ) u_dut_a (
    .clk(clk), .rst(rst_a), .D(d_a),
    .level(level_a), .rise(rise_a), .fall(fall_a), .hold(hold_a)
  );

  // Second instance: active-low inputs, single hold strobe.
  multi_debounce #(
    .CHANNELS(4), .DEBOUNCE_CYCLES(4), .HOLD_CYCLES(10),
    .REPEAT_CYCLES(0), .ACTIVE_LOW(1)
  ) u_dut_b (
    .clk(clk), .rst(rst_b), .D(d_b),
    .level(level_b), .rise(rise_b), .fall(fall_b), .hold(hold_b)
  );

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    rst_a_s <= rst_a;
    rst_b_s <= rst_b;
  end

  task automatic push_a(input int c, input logic [3:0] r, input logic [3:0] f,
                        input logic [3:0] h, input logic [3:0] l);
    exp_t e;
    e.cyc = c; e.r = r; e.f = f; e.h = h; e.l = l;
    qa.push_back(e);
  endtask

  task automatic push_b(input int c, input logic [3:0] r, input logic [3:0] f,
                        input logic [3:0] h, input logic [3:0] l);
    exp_t e;
    e.cyc = c; e.r = r; e.f = f; e.h = h; e.l = l;
    qb.push_back(e);
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic chk_zero(input string nm, input logic [3:0] l, input logic [3:0] r,
                          input logic [3:0] f, input logic [3:0] h);
    n_checks++;
    if ({l, r, f, h} !== 16'h0000) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got level=%b rise=%b fall=%b hold=%b, want all 0",
               nm, cyc, l, r, f, h);
    end
  endtask

  task automatic chk_evt(input string nm, input exp_t e, input logic [3:0] l,
                         input logic [3:0] r, input logic [3:0] f, input logic [3:0] h);
    n_checks++;
    if (cyc != e.cyc || r !== e.r || f !== e.f || h !== e.h || l !== e.l) begin
      n_fail++;
      $display("FAIL %s got cyc=%0d rise=%b fall=%b hold=%b level=%b, want cyc=%0d rise=%b fall=%b hold=%b level=%b",
               nm, cyc, r, f, h, l, e.cyc, e.r, e.f, e.h, e.l);
    end
  endtask

  // Monitor / scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (rst_a_s) begin
      chk_zero("reset_a", level_a, rise_a, fall_a, hold_a);
    end else if ((rise_a | fall_a | hold_a) != 4'b0000) begin
      if (qa.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_a cyc=%0d got rise=%b fall=%b hold=%b, want no strobe",
                 cyc, rise_a, fall_a, hold_a);
      end else begin
        e = qa.pop_front();
        chk_evt("event_a", e, level_a, rise_a, fall_a, hold_a);
      end
    end

    if (rst_b_s) begin
      chk_zero("reset_b", level_b, rise_b, fall_b, hold_b);
    end else if ((rise_b | fall_b | hold_b) != 4'b0000) begin
      if (qb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_b cyc=%0d got rise=%b fall=%b hold=%b, want no strobe",
                 cyc, rise_b, fall_b, hold_b);
      end else begin
        e = qb.pop_front();
        chk_evt("event_b", e, level_b, rise_b, fall_b, hold_b);
      end
    end

    if (stim_done) begin
      drain_cnt++;
      if ((qa.size() == 0 && qb.size() == 0) || drain_cnt > 100) begin
        while (qa.size() > 0) begin
          e = qa.pop_front();
          n_checks++;
          n_fail++;
          $display("FAIL missing_a got nothing, want event at cyc=%0d", e.cyc);
        end
        while (qb.size() > 0) begin
          e = qb.pop_front();
          n_checks++;
          n_fail++;
          $display("FAIL missing_b got nothing, want event at cyc=%0d", e.cyc);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
      end
    end
  end

  // Directed stimulus; a D change driven at negedge t is first sampled at
  // edge t+1 and accepted at edge t+6.
  initial begin
    int t, e, r;
    rst_a = 1'b1;
    rst_b = 1'b1;
    d_a   = 4'b1111;
    d_b   = 4'b1111;

    // Reset with all inputs high, then all channels press together.
    wait_cyc(3);
    rst_a = 1'b0;
    rst_b = 1'b0;
    push_a(9, 4'b1111, 4'b0000, 4'b0000, 4'b1111);
    wait_cyc(9);
    d_a = 4'b0000;
    push_a(15, 4'b0000, 4'b1111, 4'b0000, 4'b0000);

    // Glitch of 3 cycles is rejected; 4 cycles is accepted.
    wait_cyc(20);
    t = cyc;
    d_a[1] = 1'b1;
    wait_cyc(t + 3);
    d_a[1] = 1'b0;
    wait_cyc(t + 15);
    t = cyc;
    d_a[1] = 1'b1;
    push_a(t + 6, 4'b0010, 4'b0000, 4'b0000, 4'b0010);
    wait_cyc(t + 4);
    d_a[1] = 1'b0;
    push_a(t + 10, 4'b0000, 4'b0010, 4'b0000, 4'b0000);

    // Hold and auto-repeat; release lands on a repeat edge so fall wins.
    wait_cyc(t + 20);
    t = cyc;
    d_a[0] = 1'b1;
    e = t + 6;
    push_a(e,      4'b0001, 4'b0000, 4'b0000, 4'b0001);
    push_a(e + 10, 4'b0000, 4'b0000, 4'b0001, 4'b0001);
    push_a(e + 15, 4'b0000, 4'b0000, 4'b0001, 4'b0001);
    push_a(e + 20, 4'b0000, 4'b0000, 4'b0001, 4'b0001);
    wait_cyc(e + 19);
    d_a[0] = 1'b0;
    push_a(e + 25, 4'b0000, 4'b0001, 4'b0000, 4'b0000);

    // Simultaneous press on channels 2,3 with release on channel 0.
    wait_cyc(e + 35);
    t = cyc;
    d_a = 4'b0001;
    push_a(t + 6, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
    wait_cyc(t + 6);
    d_a = 4'b1100;
    push_a(t + 12, 4'b1100, 4'b0001, 4'b0000, 4'b1100);
    wait_cyc(t + 12);
    d_a = 4'b0000;
    push_a(t + 18, 4'b0000, 4'b1100, 4'b0000, 4'b0000);

    // Reset mid-hold: no fall strobe, hold count restarts after re-press.
    wait_cyc(t + 30);
    t = cyc;
    d_a[0] = 1'b1;
    r = t + 6;
    push_a(r, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
    wait_cyc(r + 6);
    rst_a = 1'b1;
    wait_cyc(r + 7);
    rst_a = 1'b0;
    push_a(r + 13, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
    push_a(r + 23, 4'b0000, 4'b0000, 4'b0001, 4'b0001);
    wait_cyc(r + 22);
    d_a[0] = 1'b0;
    push_a(r + 28, 4'b0000, 4'b0001, 4'b0000, 4'b0000);

    // Active-low instance with a single hold strobe.
    wait_cyc(r + 40);
    t = cyc;
    d_b[0] = 1'b0;
    push_b(t + 6,  4'b0001, 4'b0000, 4'b0000, 4'b0001);
    push_b(t + 16, 4'b0000, 4'b0000, 4'b0001, 4'b0001);
    wait_cyc(t + 30);
    d_b[0] = 1'b1;
    push_b(t + 36, 4'b0000, 4'b0001, 4'b0000, 4'b0000);

    wait_cyc(t + 45);
    stim_done = 1'b1;
  end

  // Absolute time limit.
  initial begin
    #1000000;
    $display("FAIL timeout got no end of test, want summary before time limit");
    $fatal(1, "time limit");
  end

endmodule
